nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle adder/subtractor controller that reuses a single `fa_4b` 4-bit full adder to add or subtract WIDTH-bit operands, one nibble per cycle, least-significant nibble first.
- Accepts operands over a valid/ready handshake and sequences nibbles through the adder with a registered carry chain.
- Presents the result, carry/borrow and signed overflow over a second valid/ready handshake.
- Serves as the shared arithmetic resource for accumulation steps in the digit-detection datapath, where area matters more than throughput.

## Interface
- `WIDTH`, 16, operand/result width; must be a multiple of 4 and at least 4.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand set presented.
- `in_ready` output 1: block can accept operands. High only in IDLE.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `c_in` input 1: carry-in for add; borrow-in for subtract.
- `sub` input 1: 0 computes a + b + c_in; 1 computes a − b − c_in.
- `out_valid` output 1: result valid. High only in DONE.
- `out_ready` input 1: consumer accepts result.
- `sum` output WIDTH: result, mod 2^WIDTH.
- `c_out` output 1: for add, the carry-out; for subtract, 1 means no borrow.
- `ovf` output 1: two's-complement signed overflow.

## Operation
**Constant.** NIB = WIDTH/4.

**IDLE**
- `in_ready` = 1.
- On `in_valid` & `in_ready`, capture into registers:
  - a_sh = `a`.
  - b_sh = `sub` ? ~`b` : `b`.
  - carry = `sub` ? ~`c_in` : `c_in`.
  - a_msb = `a`[WIDTH-1] and bmsb_eff = b_sh[WIDTH-1].
  - Clear nibble counter to 0. Go to RUN.

**RUN**
- Adder inputs each cycle: `a` = a_sh[3:0], `b` = b_sh[3:0], `c_in` = carry.
- At each edge:
  - Shift the adder's 4-bit sum into the top nibble of the result register; the result register shifts right by 4.
  - a_sh and b_sh shift right by 4.
  - carry ← adder `c_out`.
  - Counter increments.
- When the counter reaches NIB−1, that edge goes to DONE.

**DONE**
- `out_valid` = 1.
- `sum` = result register.
- `c_out` = carry.
- `ovf` = (a_msb == bmsb_eff) & (sum[WIDTH-1] != a_msb).
- On `out_valid` & `out_ready`, go to IDLE.

**Output rules**
- Outputs are stable for the whole DONE residency.
- `sum`, `c_out` and `ovf` retain their last value in IDLE and RUN, but are meaningful only while `out_valid` is high.
- `in_valid` is ignored outside IDLE, and operand inputs are not sampled there.

## Timing
**Reset**
- `rst_n` low forces IDLE immediately (asynchronous).
- Reset values: `in_ready` = 1; `out_valid`, `sum`, `c_out`, `ovf` = 0; counter, shift and carry registers = 0.

**Latency**
- Operands accepted at edge k give `out_valid` = 1 after edge k+NIB (NIB cycles in RUN).
- For WIDTH = 4: one RUN cycle, then DONE.

**Throughput**
- One operation per NIB+2 cycles minimum: accept, NIB RUN cycles, then the output handshake.
- No overlap of acceptance and output handshake.

**Back-pressure**
- While `out_ready` = 0 in DONE, the block stays in DONE indefinitely with all outputs held and `in_ready` = 0.

**Reset mid-operation**
- Aborts the operation. No `out_valid` pulse is produced, and the in-flight operands are lost.

**Counter**
- Width is $clog2(NIB), minimum 1 bit.
- The counter never wraps inside RUN, because exit occurs at NIB−1.

## Structure
**Shared package `nsa_pkg`**
- State enum type `nsa_state_t` {IDLE, RUN, DONE}.
- Constant NIBBLE_W = 4.

**Sub-module**
- One instance of the existing `fa_4b` (ports `a`, `b`, `c_in`, `s`, `c_out`) as the only arithmetic sub-module; no other adders in the block.
- Control FSM, counter and shift registers live in `nibble_serial_adder` itself.

## Test plan
- **Carry wrap:** WIDTH=16, a=0xFFFF, b=0x0001, sub=0, c_in=0 → `sum`=0x0000, `c_out`=1, `ovf`=0, `out_valid` exactly 4 cycles after acceptance.
- **Signed overflow:** a=0x7FFF, b=0x0001, sub=0, c_in=0 → `sum`=0x8000, `c_out`=0, `ovf`=1.
- **Subtract with borrow:** a=0x0005, b=0x0007, sub=1, c_in=0 → `sum`=0xFFFE, `c_out`=0 (borrow), `ovf`=0. Then a=0x8000, b=0x0001, sub=1, c_in=0 → `sum`=0x7FFF, `c_out`=1, `ovf`=1.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands → outputs unchanged, `in_ready`=0, new operands not captured. Raising `out_ready` returns the block to IDLE next edge.
- **Reset mid-run:** assert `rst_n`=0 during the 2nd RUN cycle → `out_valid`=0, `in_ready`=1, `sum`=0 immediately. The next operation (a=0x1234, b=0x4321) yields 0x5555 with normal latency.
- **WIDTH=4 instance:** a=0xF, b=0xF, sub=0, c_in=1 → `sum`=0xF, `c_out`=1, `ovf`=0, `out_valid` 1 cycle after acceptance.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package nsa_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } nsa_state_t;

endpackage

// File: rtl/fa_4b.sv
// 4-bit full adder: the single arithmetic element reused nibble by nibble.
module fa_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out
);

   logic [4:0] w_total;

   assign w_total = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
   assign s       = w_total[3:0];
   assign c_out   = w_total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract done one nibble per cycle through one fa_4b,
// with valid/ready handshakes on both the operand and the result side.
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   nsa_state_t       r_state;
   nsa_state_t       w_state_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_a_msb;
   logic             r_bmsb;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [3:0]       w_fa_s;
   logic             w_fa_cout;
   logic [WIDTH-1:0] w_res_next;
   logic             w_load;
   logic             w_last;

   fa_4b u_fa (
      .a     (r_a_sh[3:0]),
      .b     (r_b_sh[3:0]),
      .c_in  (r_carry),
      .s     (w_fa_s),
      .c_out (w_fa_cout)
   );

   // The fresh nibble enters at the top; after NIB shifts the LS nibble sits at bit 0.
   generate
      if (WIDTH == NIBBLE_W) begin : g_single
         assign w_res_next = w_fa_s;
      end else begin : g_multi
         assign w_res_next = {w_fa_s, r_res[WIDTH-1:NIBBLE_W]};
      end
   endgenerate

   assign w_load = in_valid & in_ready;
   assign w_last = (r_state == RUN) && (r_cnt == CNT_W'(NIB - 1));

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = RUN;
         end
         RUN: begin
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Visible results are latched only on the final RUN edge so they hold steady outside DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_a_msb <= 1'b0;
         r_bmsb  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_load) begin
         r_a_sh  <= a;
         r_b_sh  <= sub ? ~b : b;
         r_carry <= sub ? ~c_in : c_in;
         r_a_msb <= a[WIDTH-1];
         r_bmsb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a_sh  <= r_a_sh >> NIBBLE_W;
         r_b_sh  <= r_b_sh >> NIBBLE_W;
         r_res   <= w_res_next;
         r_carry <= w_fa_cout;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_fa_cout;
            r_ovf  <= (r_a_msb == r_bmsb) && (w_res_next[WIDTH-1] != r_a_msb);
         end
      end
   end

   assign sum   = r_sum;
   assign c_out = r_cout;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, s16;
   logic        cin16 = 1'b0, sub16 = 1'b0, co16, ovf16;

   logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0, s4;
   logic        cin4 = 1'b0, sub4 = 1'b0, co4, ovf4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(16)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .c_in(cin16), .sub(sub16),
      .out_valid(ov16), .out_ready(or16), .sum(s16), .c_out(co16), .ovf(ovf16)
   );

   nibble_serial_adder #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .c_in(cin4), .sub(sub4),
      .out_valid(ov4), .out_ready(or4), .sum(s4), .c_out(co4), .ovf(ovf4)
   );

   typedef struct {
      bit          w4;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] exp_sum;
      logic        exp_cout;
      logic        exp_ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the true values of the operands.
   task automatic model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input logic isub,
                        output logic [15:0] es, output logic ec, output logic eo);
      longint ua, ub, t, half, sa, sb, r, mask;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua = longint'(ia) & mask;
      ub = longint'(ib) & mask;
      sa = (ua >= half) ? ua - 2 * half : ua;
      sb = (ub >= half) ? ub - 2 * half : ub;
      if (isub) begin
         t  = ua - ub - longint'(icin);
         ec = (t >= 0);
         r  = sa - sb - longint'(icin);
      end else begin
         t  = ua + ub + longint'(icin);
         ec = ((t >> w) & 1) != 0;
         r  = sa + sb + longint'(icin);
      end
      es = 16'(t & mask);
      eo = (r < -half) || (r >= half);
   endtask

   function automatic logic get_ov(bit w4);
      return w4 ? ov4 : ov16;
   endfunction

   function automatic logic get_ir(bit w4);
      return w4 ? ir4 : ir16;
   endfunction

   task automatic run_op(input bit w4, input logic [15:0] ia, input logic [15:0] ib,
                         input logic icin, input logic isub,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input string tag);
      int n;
      logic [15:0] gs;
      logic gc, go;
      chk({tag, " in_ready"}, 32'(get_ir(w4)), 32'd1);
      if (w4) begin
         a4 = ia[3:0]; b4 = ib[3:0]; cin4 = icin; sub4 = isub; iv4 = 1'b1;
      end else begin
         a16 = ia; b16 = ib; cin16 = icin; sub16 = isub; iv16 = 1'b1;
      end
      @(posedge clk); #1;
      iv4 = 1'b0; iv16 = 1'b0;
      n = 0;
      while (!get_ov(w4) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, 32'(n), w4 ? 32'd1 : 32'd4);
      gs = w4 ? {12'h000, s4} : s16;
      gc = w4 ? co4 : co16;
      go = w4 ? ovf4 : ovf16;
      chk({tag, " sum"}, 32'(gs), 32'(es));
      chk({tag, " c_out"}, 32'(gc), 32'(ec));
      chk({tag, " ovf"}, 32'(go), 32'(eo));
      $display("op %s W=%0d a=%h b=%h cin=%0b sub=%0b -> sum=%h c=%0b v=%0b lat=%0d",
               tag, w4 ? 4 : 16, ia, ib, icin, isub, gs, gc, go, n);
      or4 = 1'b1; or16 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0; or16 = 1'b0;
      chk({tag, " release out_valid"}, 32'(get_ov(w4)), 32'd0);
      chk({tag, " release in_ready"}, 32'(get_ir(w4)), 32'd1);
   endtask

   initial begin
      vec_t vecs[10];
      logic [15:0] ra, rb, es;
      logic rc, rs, ec, eo;
      int n;

      vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 16'h000F, 16'h000F, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1};
      vecs[9] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0};

      #12;
      chk("reset in_ready16", 32'(ir16), 32'd1);
      chk("reset out_valid16", 32'(ov16), 32'd0);
      chk("reset sum16", 32'(s16), 32'd0);
      chk("reset c_out16", 32'(co16), 32'd0);
      chk("reset ovf16", 32'(ovf16), 32'd0);
      chk("reset in_ready4", 32'(ir4), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].w4, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));
      end

      // Back-pressure: hold DONE while offering new operands every cycle.
      run_op(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "bp_prev");
      a16 = 16'h1111; b16 = 16'h2222; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      n = 0;
      while (!ov16 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp latency", 32'(n), 32'd4);
      for (int i = 0; i < 5; i++) begin
         a16 = 16'(16'hF000 + i); b16 = 16'hFFFF; sub16 = 1'b1; iv16 = 1'b1;
         @(posedge clk); #1;
         chk("bp out_valid", 32'(ov16), 32'd1);
         chk("bp in_ready", 32'(ir16), 32'd0);
         chk("bp sum", 32'(s16), 32'h3333);
         chk("bp c_out", 32'(co16), 32'd0);
         $display("bp hold cycle %0d sum=%h out_valid=%0b in_ready=%0b", i, s16, ov16, ir16);
      end
      iv16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
      chk("bp release out_valid", 32'(ov16), 32'd0);
      chk("bp release in_ready", 32'(ir16), 32'd1);
      chk("bp idle sum held", 32'(s16), 32'h3333);
      @(posedge clk); #1;
      chk("bp no capture out_valid", 32'(ov16), 32'd0);

      // Reset in the second RUN cycle aborts the operation.
      a16 = 16'hAAAA; b16 = 16'h5555; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst out_valid", 32'(ov16), 32'd0);
      chk("rst in_ready", 32'(ir16), 32'd1);
      chk("rst sum", 32'(s16), 32'd0);
      $display("reset mid-run: sum=%h out_valid=%0b in_ready=%0b", s16, ov16, ir16);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst no pulse", 32'(ov16), 32'd0);
      run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "post_rst");

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         model(16, ra, rb, rc, rs, es, ec, eo);
         run_op(1'b0, ra, rb, rc, rs, es, ec, eo, $sformatf("rnd16_%0d", i));
      end
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom_range(0, 15));
         rb = 16'($urandom_range(0, 15));
         rc = 1'($urandom);
         rs = 1'($urandom);
         model(4, ra, rb, rc, rs, es, ec, eo);
         run_op(1'b1, ra, rb, rc, rs, es, ec, eo, $sformatf("rnd4_%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
